tx_bus_arb: RTL and testbench
=============================

Name: tx_bus_arb

Overview:
- Frame-level round-robin arbiter that shares the single UART byte sender between N frame generators, such as sensor-reply generators and status/heartbeat generators.
- Sits between the generators and the UART transmit module.
- A granted source owns the sender for a whole frame, until it marks the last byte or the grant is released.
- Includes a per-byte inactivity watchdog so a stalled source cannot lock the bus.

Parameters:
N, 4, number of requesting frame sources (2..8)
IDW, 2, width of owner index; must satisfy 2**IDW >= N
TIMEOUT_CYC, 50000, max cycles the owner may idle between bytes before grant is revoked (fits in 16 bits)

Ports:
sys_clk  input  1  system clock
sys_rst  input  1  reset, asynchronous, active-low
src_req  input  N  source i requests the bus; level, held for the whole frame
src_data  input  N*8  byte from source i at bits [8i+7:8i]
src_data_flag  input  N  1-cycle pulse: source i byte valid
src_last  input  N  qualifies src_data_flag: this is the frame's last byte
src_gnt  output  N  one-hot grant, level
src_send_finish  output  N  1-cycle pulse to owner: its byte left the UART
bus_data  output  8  byte to UART sender
bus_data_flag  output  1  1-cycle pulse: bus_data valid
bus_send_finish  input  1  1-cycle pulse from UART: byte transmitted
owner_id  output  IDW  index of current/last owner
busy  output  1  high while any grant is held
timeout_err  output  1  1-cycle pulse when a grant is revoked by the watchdog

Behaviour:
- Reset values: all outputs 0, FSM in S_IDLE, rr pointer last_owner = N-1 (so port 0 wins the first tie), timeout counter 0.
- Reset is asynchronous and active-low. Assertion mid-frame drops the grant and any in-flight flag immediately. A byte already inside the UART is not tracked after reset.
- FSM states: S_IDLE, S_OWN (wait for a byte from the owner), S_BUSY (byte in flight, wait for UART).
- S_IDLE:
  - If any src_req is high, pick the first requester at or after last_owner+1, modulo N.
  - Next cycle: src_gnt[k]=1, owner_id=k, busy=1, last_owner<=k, timeout counter cleared, go to S_OWN.
  - Latency from src_req to src_gnt is 1 cycle.
- S_OWN:
  - src_data_flag[k]=1 at cycle t gives, at t+1: bus_data = slice k, bus_data_flag=1 for exactly one cycle, last_latched = src_last[k], go to S_BUSY.
  - src_req[k]=0 with no flag in the same cycle: release. src_gnt=0 next cycle, go to S_IDLE, no error.
  - If flag and req drop coincide, the byte wins and is treated as last.
  - Timeout counter increments each cycle. Reaching TIMEOUT_CYC-1 with no flag: grant revoked, timeout_err pulse, go to S_IDLE.
- S_BUSY:
  - Wait for bus_send_finish. On it at t: src_send_finish[k]=1 at t+1 for 1 cycle.
  - If last_latched: src_gnt=0 and busy=0 at t+1, go to S_IDLE.
  - Else: counter cleared, go to S_OWN.
  - No timeout in S_BUSY; the UART is trusted.
  - src_req drop in S_BUSY is ignored until finish.
- Ignored inputs:
  - src_data_flag from non-owners is always ignored.
  - An owner flag while in S_BUSY is ignored; sources must wait for src_send_finish.
  - bus_send_finish outside S_BUSY is ignored.
- Re-arbitration: IDLE to next grant takes at least 1 idle cycle between frames.
- Fairness: with continuous requests, grants rotate strictly.
- owner_id holds its value after release.
- All outputs are registered.

Decomposition:
- Shared package tx_arb_pkg:
  - FSM state encoding (S_IDLE/S_OWN/S_BUSY).
  - Timeout counter width constant (16).
  - Helper function for one-hot from index.
- One natural sub-module: rr_pick, a combinational N-way round-robin picker.
  - Inputs: req vector, last_owner.
  - Outputs: valid, index.

Test Plan:
- Single frame:
  - Stimulus: src_req[1]=1; bytes 0xA5, 0x5A, 0x04 with src_last on 0x04; UART returns finish 10 cycles after each flag.
  - Response: src_gnt=0010 one cycle after req; bus_data sequence A5, 5A, 04, each flag 1 cycle; 3 src_send_finish[1] pulses; gnt=0 the cycle after the third finish.
- Round-robin:
  - Stimulus: src_req=1111 held; each source sends 2-byte frames.
  - Response: grant order 0,1,2,3,0; owner_id matches the order.
- Watchdog:
  - Stimulus: TIMEOUT_CYC=20; port 2 granted, sends 1 non-last byte, then goes silent.
  - Response: timeout_err pulse exactly 20 cycles after the src_send_finish pulse; gnt cleared; port 3 granted next if requesting.
- Interference:
  - Stimulus: while port 0 owns, pulse src_data_flag[3]=1 with 0xFF; pulse bus_send_finish during S_OWN.
  - Response: no bus_data_flag; no src_send_finish; state unchanged.
- Release:
  - Stimulus: port 1 drops src_req in S_OWN after 1 byte.
  - Response: gnt=0 next cycle; no timeout_err.
- Reset mid-frame:
  - Stimulus: sys_rst low during S_BUSY.
  - Response: all outputs 0 asynchronously; after release, port 0 wins a 0011 tie.

Source files
------------

// File: rtl/tx_bus_arb_pkg.sv
// tx_arb_pkg: shared state encoding, counter width and one-hot helper for tx_bus_arb
package tx_arb_pkg;
  typedef enum logic [1:0] {S_IDLE, S_OWN, S_BUSY} state_t;
  localparam int TO_W = 16;
  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'(1) << idx;
  endfunction
endpackage

// File: rtl/tx_bus_arb_if.sv
// tx_bus_arb_if: frame sources, UART sender and status signals around the arbiter
interface tx_bus_arb_if #(parameter int N = 4, parameter int IDW = 2);
  logic [N-1:0]   src_req;
  logic [N*8-1:0] src_data;
  logic [N-1:0]   src_data_flag;
  logic [N-1:0]   src_last;
  logic [N-1:0]   src_gnt;
  logic [N-1:0]   src_send_finish;
  logic [7:0]     bus_data;
  logic           bus_data_flag;
  logic           bus_send_finish;
  logic [IDW-1:0] owner_id;
  logic           busy;
  logic           timeout_err;
  modport master (
    input  src_req, src_data, src_data_flag, src_last, bus_send_finish,
    output src_gnt, src_send_finish, bus_data, bus_data_flag, owner_id, busy, timeout_err
  );
  modport slave (
    output src_req, src_data, src_data_flag, src_last, bus_send_finish,
    input  src_gnt, src_send_finish, bus_data, bus_data_flag, owner_id, busy, timeout_err
  );
endinterface

// File: rtl/tx_bus_arb_rr_pick.sv
// rr_pick: combinational round-robin picker, first requester after i_last wins
module rr_pick #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [IDW-1:0] i_last,
  output logic           o_valid,
  output logic [IDW-1:0] o_idx
);
  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    // scan from farthest to nearest so the slot right after i_last overrides
    for (int i = N; i >= 1; i--) begin
      logic [IDW-1:0] j;
      j = IDW'((int'(i_last) + i) % N);
      if (i_req[j]) o_idx = j;
    end
  end
endmodule

// File: rtl/tx_bus_arb.sv
// tx_bus_arb: frame-level round-robin arbiter sharing one UART sender with a per-byte watchdog
module tx_bus_arb
  import tx_arb_pkg::*;
#(
  parameter int N           = 4,
  parameter int IDW         = 2,
  parameter int TIMEOUT_CYC = 50000
) (
  input logic          sys_clk,
  input logic          sys_rst,
  tx_bus_arb_if.master bus
);
  state_t          r_state, w_state;
  logic [IDW-1:0]  r_owner, w_owner, r_last_owner, w_last_owner;
  logic [TO_W-1:0] r_cnt, w_cnt;
  logic            r_last_latched, w_last_latched;
  logic [N-1:0]    r_gnt, w_gnt, r_ssf, w_ssf;
  logic            r_busy, w_busy, r_flag, w_flag, r_err, w_err;
  logic [7:0]      r_data, w_data;
  logic            w_pick_v;
  logic [IDW-1:0]  w_pick;
  logic [N-1:0]    w_pick_oh;
  logic            w_own_flag, w_own_req;
  logic [7:0]      w_own_byte;

  rr_pick #(.N(N), .IDW(IDW)) u_pick (
    .i_req  (bus.src_req),
    .i_last (r_last_owner),
    .o_valid(w_pick_v),
    .o_idx  (w_pick)
  );

  assign w_pick_oh  = N'(onehot(3'(w_pick)));
  assign w_own_flag = bus.src_data_flag[r_owner];
  assign w_own_req  = bus.src_req[r_owner];
  assign w_own_byte = bus.src_data[{r_owner, 3'b000} +: 8];

  always_comb begin
    w_state        = r_state;
    w_owner        = r_owner;
    w_last_owner   = r_last_owner;
    w_cnt          = r_cnt;
    w_last_latched = r_last_latched;
    w_gnt          = r_gnt;
    w_busy         = r_busy;
    w_data         = r_data;
    w_flag         = 1'b0;
    w_ssf          = '0;
    w_err          = 1'b0;
    case (r_state)
      S_IDLE: if (w_pick_v) begin
        w_state      = S_OWN;
        w_owner      = w_pick;
        w_last_owner = w_pick;
        w_cnt        = '0;
        w_gnt        = w_pick_oh;
        w_busy       = 1'b1;
      end
      S_OWN: if (w_own_flag) begin
        w_state        = S_BUSY;
        w_data         = w_own_byte;
        w_flag         = 1'b1;
        // a byte arriving together with a dropped request closes the frame
        w_last_latched = bus.src_last[r_owner] | ~w_own_req;
      end else if (!w_own_req || r_cnt == TO_W'(TIMEOUT_CYC - 1)) begin
        w_state = S_IDLE;
        w_gnt   = '0;
        w_busy  = 1'b0;
        w_err   = w_own_req;
      end else begin
        w_cnt = r_cnt + 1'b1;
      end
      S_BUSY: if (bus.bus_send_finish) begin
        w_ssf   = r_gnt;
        w_state = r_last_latched ? S_IDLE : S_OWN;
        w_gnt   = r_last_latched ? '0 : r_gnt;
        w_busy  = ~r_last_latched;
        w_cnt   = '0;
      end
      default: w_state = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      r_state        <= S_IDLE;
      r_owner        <= '0;
      r_last_owner   <= IDW'(N - 1);
      r_cnt          <= '0;
      r_last_latched <= 1'b0;
      r_gnt          <= '0;
      r_busy         <= 1'b0;
      r_data         <= '0;
      r_flag         <= 1'b0;
      r_ssf          <= '0;
      r_err          <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_owner        <= w_owner;
      r_last_owner   <= w_last_owner;
      r_cnt          <= w_cnt;
      r_last_latched <= w_last_latched;
      r_gnt          <= w_gnt;
      r_busy         <= w_busy;
      r_data         <= w_data;
      r_flag         <= w_flag;
      r_ssf          <= w_ssf;
      r_err          <= w_err;
    end
  end

  assign bus.src_gnt         = r_gnt;
  assign bus.src_send_finish = r_ssf;
  assign bus.bus_data        = r_data;
  assign bus.bus_data_flag   = r_flag;
  assign bus.owner_id        = r_owner;
  assign bus.busy            = r_busy;
  assign bus.timeout_err     = r_err;
endmodule

// File: tb/tb_tx_bus_arb.sv
// tb_tx_bus_arb: scoreboard bench for tx_bus_arb covering frames, rotation, watchdog, interference, release and reset
module tb_tx_bus_arb;
  localparam int N = 4, IDW = 2, TO = 20;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  tx_bus_arb_if #(.N(N), .IDW(IDW)) bus();
  tx_bus_arb #(.N(N), .IDW(IDW), .TIMEOUT_CYC(TO)) dut (
    .sys_clk(clk),
    .sys_rst(rst_n),
    .bus    (bus)
  );

  int n_chk = 0, n_fail = 0, n_err = 0, e0;
  logic [9:0] sb[$];
  logic [9:0] e;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.timeout_err) n_err++;
    if (bus.bus_data_flag) begin
      if (sb.size() == 0) chk("unexpected_flag", bus.bus_data_flag, 0);
      else begin
        e = sb.pop_front();
        chk("bus_data", bus.bus_data, e[7:0]);
        chk("flag_owner", bus.owner_id, e[9:8]);
      end
    end
  end

  task automatic wait_gnt(input int s);
    int k = 0;
    do begin @(negedge clk); k++; end while (bus.src_gnt == 0 && k < 4);
    chk("gnt_latency", k, 1);
    chk("gnt", bus.src_gnt, 1 << s);
    chk("owner_id", bus.owner_id, s);
    chk("busy", bus.busy, 1);
  endtask

  task automatic send_byte(input int s, input logic [7:0] b, input bit last, input bit drop);
    @(negedge clk);
    bus.src_data[8*s +: 8] = b;
    bus.src_data_flag[s] = 1'b1;
    bus.src_last[s] = last;
    sb.push_back({2'(s), b});
    @(negedge clk);
    bus.src_data_flag[s] = 1'b0;
    bus.src_last[s] = 1'b0;
    repeat (9) @(negedge clk);
    bus.bus_send_finish = 1'b1;
    if (drop) bus.src_req = '0;
    @(negedge clk);
    bus.bus_send_finish = 1'b0;
    chk("send_finish", bus.src_send_finish, 1 << s);
    if (last) begin
      chk("gnt_after_last", bus.src_gnt, 0);
      chk("busy_after_last", bus.busy, 0);
    end
  endtask

  task automatic do_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.src_req = '0; bus.src_data = '0; bus.src_data_flag = '0;
    bus.src_last = '0; bus.bus_send_finish = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", bus.src_gnt, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_owner", bus.owner_id, 0);
    chk("rst_flag", bus.bus_data_flag, 0);
    chk("rst_ssf", bus.src_send_finish, 0);
    chk("rst_err", bus.timeout_err, 0);
    rst_n = 1'b1;
    // single frame from port 1
    bus.src_req = 4'b0010;
    wait_gnt(1);
    send_byte(1, 8'hA5, 0, 0);
    send_byte(1, 8'h5A, 0, 0);
    send_byte(1, 8'h04, 1, 1);
    // strict rotation from a fresh pointer
    do_reset();
    bus.src_req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_gnt(k % 4);
      send_byte(k % 4, 8'(8'h10 + k), 0, 0);
      send_byte(k % 4, 8'(8'h20 + k), 1, k == 4);
    end
    // watchdog: port 2 stalls after one byte, port 3 waits
    bus.src_req = 4'b1100;
    wait_gnt(2);
    send_byte(2, 8'h3C, 0, 0);
    e0 = n_err;
    repeat (19) @(negedge clk);
    chk("timeout_early", bus.timeout_err, 0);
    @(negedge clk);
    chk("timeout_err", bus.timeout_err, 1);
    chk("timeout_gnt", bus.src_gnt, 0);
    bus.src_req[2] = 1'b0;
    wait_gnt(3);
    chk("timeout_pulse_len", bus.timeout_err, 0);
    chk("timeout_count", n_err - e0, 1);
    send_byte(3, 8'hC3, 1, 1);
    // interference while port 0 owns
    bus.src_req = 4'b0001;
    wait_gnt(0);
    @(negedge clk);
    bus.src_data[31:24] = 8'hFF;
    bus.src_data_flag[3] = 1'b1;
    @(negedge clk);
    bus.src_data_flag[3] = 1'b0;
    chk("intf_no_flag", bus.bus_data_flag, 0);
    bus.bus_send_finish = 1'b1;
    @(negedge clk);
    bus.bus_send_finish = 1'b0;
    chk("intf_no_ssf", bus.src_send_finish, 0);
    chk("intf_gnt", bus.src_gnt, 4'b0001);
    send_byte(0, 8'h77, 1, 1);
    // voluntary release after one byte
    bus.src_req = 4'b0010;
    wait_gnt(1);
    send_byte(1, 8'h42, 0, 0);
    e0 = n_err;
    bus.src_req = '0;
    @(negedge clk);
    chk("release_gnt", bus.src_gnt, 0);
    chk("release_busy", bus.busy, 0);
    repeat (TO + 5) @(negedge clk);
    chk("release_no_timeout", n_err - e0, 0);
    chk("owner_hold", bus.owner_id, 1);
    // reset while a byte is in flight
    bus.src_req = 4'b0001;
    wait_gnt(0);
    @(negedge clk);
    bus.src_data[7:0] = 8'h55;
    bus.src_data_flag[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("pre_reset_flag", bus.bus_data_flag, 1);
    rst_n = 1'b0;
    #1;
    chk("async_gnt", bus.src_gnt, 0);
    chk("async_flag", bus.bus_data_flag, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_owner", bus.owner_id, 0);
    bus.src_data_flag[0] = 1'b0;
    bus.src_req = 4'b0011;
    @(negedge clk);
    rst_n = 1'b1;
    wait_gnt(0);
    send_byte(0, 8'h99, 1, 1);
    sb.delete();
    repeat (3) @(negedge clk);
    chk("idle_end", bus.busy, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
